md_sequencer: RTL and testbench
===============================

Name: md_sequencer

Overview:
Multi-cycle multiply/divide controller for the execute stage. It accepts one MULT/MULTU/DIV/DIVU request from decode and runs either a fixed-latency multiply or a 32-iteration restoring divide. It raises busy so the hazard unit stalls dependants, then delivers the 64-bit {HI,LO} result with a one-cycle write pulse toward writeback's double-write path.

Parameters:
MUL_LAT, 2, multiply latency in cycles from accept to done pulse; legal range 1..8.
DIV_ITERS, 32, divide iterations (one per cycle); fixed at 32 for a 32-bit datapath.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
mult_en  in  1  multiply request, sampled only in IDLE
div_en  in  1  divide request, sampled only in IDLE
is_signed  in  1  1 = signed operation (MULT/DIV), 0 = unsigned
md_src1  in  32  multiplicand / dividend
md_src2  in  32  multiplier / divisor
cancel  in  1  abort in-flight operation (pipeline flush)
busy  out  1  operation in flight; feeds hazard-unit stall
done  out  1  one-cycle pulse; result valid this cycle
double_en  out  1  equals done; HI/LO write enable to writeback
md_result  out  64  {HI,LO}; HI = high product / remainder, LO = low product / quotient

Behaviour:
- Reset (async, resetn=0): state IDLE, counters 0, busy=0, done=0, double_en=0, md_result=0.
- States: IDLE, MUL, DIV, FIX, DONE.
- Accept: in IDLE, at the rising edge where mult_en or div_en is 1, operands and is_signed are latched. If both are 1, mult wins and div_en is ignored. Requests in any other state are ignored; decode does not issue while busy.
- busy = (state != IDLE). It is registered, so it is high starting the cycle after accept and through the DONE cycle.
- MUL:
  - Product is sign- or zero-extended to 33x33 and truncated to 64 bits.
  - Counter runs 1..MUL_LAT-1, then the machine enters DONE.
  - done is high exactly MUL_LAT cycles after the accept edge. With MUL_LAT=1, the machine goes directly to DONE.
- DIV:
  - Operands are converted to magnitudes when is_signed.
  - One restoring shift-subtract step per cycle for DIV_ITERS cycles, then FIX for one cycle.
  - FIX negates the quotient if the signs differ and negates the remainder if the dividend is negative (signed only). It then enters DONE.
  - done is high 34 cycles after the accept edge.
- Divide by zero: no exception. md_result = {md_src1, 32'hFFFFFFFF}, regardless of is_signed, delivered with normal divide timing.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DONE: done=double_en=1 for one cycle, md_result is updated in that same cycle, then the machine returns to IDLE. A new request may be accepted in the cycle after DONE; a request during DONE is ignored.
- md_result holds its last value until the next DONE. It is never changed mid-operation.
- cancel:
  - In MUL, DIV or FIX: return to IDLE on the next edge, no done pulse, md_result unchanged.
  - In DONE: has no effect; the pulse completes.
  - In IDLE together with a request: the request is not accepted.
- resetn low mid-operation aborts immediately. No done is produced and md_result is cleared to 0.

Test Plan:
- Signed mult -3 x 5, MUL_LAT=2 -> done 2 cycles after accept, md_result=0xFFFFFFFF_FFFFFFF1, busy high for 2 cycles.
- Unsigned mult 0xFFFFFFFF x 2 -> md_result=0x00000001_FFFFFFFE; same operands signed -> 0xFFFFFFFF_FFFFFFFE.
- Unsigned div 100 / 7 -> done at accept+34, LO=0x0000000E, HI=0x00000002. Signed -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Div by zero, src1=0x12345678 -> md_result=0x12345678_FFFFFFFF. Signed 0x80000000 / -1 -> 0x00000000_80000000.
- cancel asserted at accept+10 of a divide -> IDLE next cycle, no done, previous md_result retained. A new mult accepted the following cycle completes normally.
- resetn dropped mid-divide -> busy, done and md_result go to 0 asynchronously. Simultaneous mult_en and div_en -> multiply executed. Request issued while busy -> ignored, with only one done pulse.

Source files
------------

// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - multi-cycle multiply/divide sequencer producing {HI,LO}
module md_sequencer #(
    parameter int MUL_LAT   = 2,
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mult_en,
    input  logic        div_en,
    input  logic        is_signed,
    input  logic [31:0] md_src1,
    input  logic [31:0] md_src2,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic        double_en,
    output logic [63:0] md_result
);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    localparam logic [5:0] MUL_LAST = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_LAST = 6'(DIV_ITERS - 1);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q;
    logic [31:0] a_q, b_q;
    logic        s_q;
    logic [31:0] quo_q, rem_q, dvs_q;
    logic [63:0] result_q;

    logic [32:0] rem_shift, rem_diff;
    logic        dvd_neg, dvs_neg;
    logic [31:0] quo_fix, rem_fix;
    logic [63:0] div_result;

    // Extending to 64 bits before multiplying gives the same low 64 bits as a 33x33 product.
    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] ax, bx;
        ax = s ? {{32{a[31]}}, a} : {32'b0, a};
        bx = s ? {{32{b[31]}}, b} : {32'b0, b};
        return ax * bx;
    endfunction

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic s);
        return (s && v[31]) ? (~v + 32'd1) : v;
    endfunction

    // Restoring divide step and final sign fix-up, evaluated from the registered operands.
    always_comb begin
        rem_shift  = {rem_q, quo_q[31]};
        rem_diff   = rem_shift - {1'b0, dvs_q};
        dvd_neg    = s_q & a_q[31];
        dvs_neg    = s_q & b_q[31];
        quo_fix    = (dvd_neg ^ dvs_neg) ? (~quo_q + 32'd1) : quo_q;
        rem_fix    = dvd_neg ? (~rem_q + 32'd1) : rem_q;
        div_result = (b_q == 32'd0) ? {a_q, 32'hFFFF_FFFF} : {rem_fix, quo_fix};
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic: mult has priority over div; cancel aborts anything but DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!cancel && mult_en)     state_d = (MUL_LAT == 1) ? S_DONE : S_MUL;
                else if (!cancel && div_en) state_d = S_DIV;
            end
            S_MUL: begin
                if (cancel)                 state_d = S_IDLE;
                else if (cnt_q == MUL_LAST) state_d = S_DONE;
            end
            S_DIV: begin
                if (cancel)                 state_d = S_IDLE;
                else if (cnt_q == DIV_LAST) state_d = S_FIX;
            end
            S_FIX:  state_d = cancel ? S_IDLE : S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration counter, divide step, result load on DONE entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q    <= 6'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            s_q      <= 1'b0;
            quo_q    <= 32'd0;
            rem_q    <= 32'd0;
            dvs_q    <= 32'd0;
            result_q <= 64'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (state_d != S_IDLE) begin
                        a_q   <= md_src1;
                        b_q   <= md_src2;
                        s_q   <= is_signed;
                        quo_q <= mag32(md_src1, is_signed);
                        rem_q <= 32'd0;
                        dvs_q <= mag32(md_src2, is_signed);
                        cnt_q <= (state_d == S_MUL) ? 6'd1 : 6'd0;
                    end
                    if (state_d == S_DONE) result_q <= mul64(md_src1, md_src2, is_signed);
                end
                S_MUL: begin
                    cnt_q <= (state_d == S_MUL) ? cnt_q + 6'd1 : 6'd0;
                    if (state_d == S_DONE) result_q <= mul64(a_q, b_q, s_q);
                end
                S_DIV: begin
                    cnt_q <= (state_d == S_DIV) ? cnt_q + 6'd1 : 6'd0;
                    if (!rem_diff[32]) begin
                        rem_q <= rem_diff[31:0];
                        quo_q <= {quo_q[30:0], 1'b1};
                    end else begin
                        rem_q <= rem_shift[31:0];
                        quo_q <= {quo_q[30:0], 1'b0};
                    end
                end
                S_FIX: begin
                    if (state_d == S_DONE) result_q <= div_result;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from the registered state.
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        double_en = (state_q == S_DONE);
        md_result = result_q;
    end

endmodule

// File: tb/tb_md_sequencer.sv
// tb/tb_md_sequencer.sv - directed self-checking bench for md_sequencer
module tb_md_sequencer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mult_en, div_en, is_signed, cancel;
    logic [31:0] md_src1, md_src2;
    logic        busy, done, double_en;
    logic [63:0] md_result;

    int pass_cnt = 0;
    int total_cnt = 0;

    md_sequencer #(.MUL_LAT(2), .DIV_ITERS(32)) dut (
        .clk(clk), .resetn(resetn), .mult_en(mult_en), .div_en(div_en),
        .is_signed(is_signed), .md_src1(md_src1), .md_src2(md_src2), .cancel(cancel),
        .busy(busy), .done(done), .double_en(double_en), .md_result(md_result)
    );

    always #5 clk = ~clk;

    // Issue one request, then sample on negedges until done (bounded); lat=-1 if it never came.
    task automatic run_op(input logic m, input logic d, input logic s, input logic [31:0] a,
                          input logic [31:0] b, output int lat, output int busy_cycles,
                          output logic dbl, output logic [63:0] res);
        @(negedge clk);
        mult_en = m; div_en = d; is_signed = s; md_src1 = a; md_src2 = b;
        @(negedge clk);
        mult_en = 0; div_en = 0;
        lat = -1; busy_cycles = 0; dbl = 0; res = 64'hX;
        for (int k = 1; k <= 100; k++) begin
            if (busy) busy_cycles++;
            if (done) begin
                lat = k; dbl = double_en; res = md_result;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        resetn = 0; mult_en = 0; div_en = 0; is_signed = 0; cancel = 0;
        md_src1 = 0; md_src2 = 0;
        repeat (2) @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else pass_cnt++;
        total_cnt++; if (double_en !== 1'b0) $display("FAIL reset_double_en got %b exp 0", double_en); else pass_cnt++;
        total_cnt++; if (md_result !== 64'd0) $display("FAIL reset_result got %h exp 0", md_result); else pass_cnt++;
        resetn = 1;
    endtask

    task automatic test_mult();
        int lat, bc; logic dbl; logic [63:0] res;
        run_op(1, 0, 1, 32'hFFFF_FFFD, 32'd5, lat, bc, dbl, res);
        total_cnt++; if (lat !== 2) $display("FAIL mul_latency got %0d exp 2", lat); else pass_cnt++;
        total_cnt++; if (res !== 64'hFFFF_FFFF_FFFF_FFF1) $display("FAIL mul_s_neg3x5 got %h exp FFFFFFFFFFFFFFF1", res); else pass_cnt++;
        total_cnt++; if (dbl !== 1'b1) $display("FAIL mul_double_en got %b exp 1", dbl); else pass_cnt++;
        total_cnt++; if (bc !== 2) $display("FAIL mul_busy_cycles got %0d exp 2", bc); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (done !== 1'b0) $display("FAIL mul_done_one_cycle got %b exp 0", done); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL mul_busy_after got %b exp 0", busy); else pass_cnt++;
        total_cnt++; if (md_result !== 64'hFFFF_FFFF_FFFF_FFF1) $display("FAIL mul_result_hold got %h exp FFFFFFFFFFFFFFF1", md_result); else pass_cnt++;
        run_op(1, 0, 0, 32'hFFFF_FFFF, 32'd2, lat, bc, dbl, res);
        total_cnt++; if (res !== 64'h0000_0001_FFFF_FFFE) $display("FAIL mul_u_ffff_x2 got %h exp 00000001FFFFFFFE", res); else pass_cnt++;
        run_op(1, 0, 1, 32'hFFFF_FFFF, 32'd2, lat, bc, dbl, res);
        total_cnt++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE) $display("FAIL mul_s_ffff_x2 got %h exp FFFFFFFFFFFFFFFE", res); else pass_cnt++;
    endtask

    task automatic test_div();
        int lat, bc; logic dbl; logic [63:0] res;
        run_op(0, 1, 0, 32'd100, 32'd7, lat, bc, dbl, res);
        total_cnt++; if (lat !== 34) $display("FAIL div_latency got %0d exp 34", lat); else pass_cnt++;
        total_cnt++; if (res !== 64'h0000_0002_0000_000E) $display("FAIL div_u_100_7 got %h exp 000000020000000E", res); else pass_cnt++;
        total_cnt++; if (bc !== 34) $display("FAIL div_busy_cycles got %0d exp 34", bc); else pass_cnt++;
        run_op(0, 1, 1, 32'hFFFF_FFF9, 32'd2, lat, bc, dbl, res);
        total_cnt++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) $display("FAIL div_s_neg7_2 got %h exp FFFFFFFFFFFFFFFD", res); else pass_cnt++;
    endtask

    task automatic test_div_corner();
        int lat, bc; logic dbl; logic [63:0] res;
        run_op(0, 1, 1, 32'h1234_5678, 32'd0, lat, bc, dbl, res);
        total_cnt++; if (lat !== 34) $display("FAIL divzero_latency got %0d exp 34", lat); else pass_cnt++;
        total_cnt++; if (res !== 64'h1234_5678_FFFF_FFFF) $display("FAIL divzero_result got %h exp 12345678FFFFFFFF", res); else pass_cnt++;
        run_op(0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, dbl, res);
        total_cnt++; if (res !== 64'h0000_0000_8000_0000) $display("FAIL div_overflow got %h exp 0000000080000000", res); else pass_cnt++;
    endtask

    task automatic test_cancel();
        int lat, bc; logic dbl; logic [63:0] res; logic saw_done;
        saw_done = 0;
        @(negedge clk);
        div_en = 1; is_signed = 0; md_src1 = 32'd100; md_src2 = 32'd7;
        @(negedge clk);
        div_en = 0;
        for (int k = 1; k < 10; k++) begin
            if (done) saw_done = 1;
            @(negedge clk);
        end
        cancel = 1;
        @(negedge clk);
        total_cnt++; if (saw_done !== 1'b0) $display("FAIL cancel_early_done got %b exp 0", saw_done); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL cancel_busy got %b exp 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL cancel_done got %b exp 0", done); else pass_cnt++;
        total_cnt++; if (md_result !== 64'h0000_0000_8000_0000) $display("FAIL cancel_retain got %h exp 0000000080000000", md_result); else pass_cnt++;
        cancel = 0;
        mult_en = 1; md_src1 = 32'd6; md_src2 = 32'd7;
        @(negedge clk);
        mult_en = 0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            if (done) begin lat = k; res = md_result; break; end
            @(negedge clk);
        end
        total_cnt++; if (lat !== 2) $display("FAIL cancel_next_latency got %0d exp 2", lat); else pass_cnt++;
        total_cnt++; if (res !== 64'd42) $display("FAIL cancel_next_result got %h exp 000000000000002A", res); else pass_cnt++;
        @(negedge clk);
        cancel = 1; mult_en = 1; md_src1 = 32'd9; md_src2 = 32'd9;
        @(negedge clk);
        cancel = 0; mult_en = 0;
        total_cnt++; if (busy !== 1'b0) $display("FAIL cancel_idle_accept got %b exp 0", busy); else pass_cnt++;
        bc = 0; dbl = 0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        div_en = 1; is_signed = 0; md_src1 = 32'd500; md_src2 = 32'd3;
        @(negedge clk);
        div_en = 0;
        repeat (4) @(negedge clk);
        total_cnt++; if (busy !== 1'b1) $display("FAIL rstmid_busy_before got %b exp 1", busy); else pass_cnt++;
        #2 resetn = 0;
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b exp 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL rstmid_done got %b exp 0", done); else pass_cnt++;
        total_cnt++; if (md_result !== 64'd0) $display("FAIL rstmid_result got %h exp 0", md_result); else pass_cnt++;
        @(negedge clk);
        resetn = 1;
    endtask

    task automatic test_priority();
        int lat, bc; logic dbl; logic [63:0] res;
        run_op(1, 1, 0, 32'd3, 32'd4, lat, bc, dbl, res);
        total_cnt++; if (lat !== 2) $display("FAIL both_latency got %0d exp 2", lat); else pass_cnt++;
        total_cnt++; if (res !== 64'd12) $display("FAIL both_result got %h exp 000000000000000C", res); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int ndone;
        ndone = 0;
        @(negedge clk);
        mult_en = 1; is_signed = 0; md_src1 = 32'd2; md_src2 = 32'd3;
        @(negedge clk);
        mult_en = 0; div_en = 1; md_src1 = 32'd100; md_src2 = 32'd7;
        for (int k = 1; k <= 40; k++) begin
            if (done) ndone++;
            if (k == 2) mult_en = 1;
            if (k == 3) begin mult_en = 0; div_en = 0; end
            @(negedge clk);
        end
        total_cnt++; if (ndone !== 1) $display("FAIL busy_req_done_count got %0d exp 1", ndone); else pass_cnt++;
        total_cnt++; if (md_result !== 64'd6) $display("FAIL busy_req_result got %h exp 0000000000000006", md_result); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL busy_req_idle got %b exp 0", busy); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_corner();
        test_cancel();
        test_reset_mid();
        test_priority();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
